// File: rtl/gate_char_sequencer.sv
// Purpose: steps a 2-input gate through {x,y}=00..11, samples its output after a settle time and checks it against a latched truth table.
// Latency: done pulses 4*REPEAT*(SETTLE_CYCLES+2) cycles after the accepting edge; each vector takes APPLY + SETTLE_CYCLES + SAMPLE.
// Backpressure: none; start is only sampled in IDLE, so requests while busy are dropped. Optional macro GATE_CHAR_STUCK_DETECT_EN enables the stuck flag.
module gate_char_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int REPEAT        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       truth_table,
  output logic             dut_x,
  output logic             dut_y,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic             stuck
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
  localparam logic [PW-1:0] LAST_PASS = PW'(REPEAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_tt;
  logic [1:0]       r_idx;
  logic [PW-1:0]    r_pass_cnt;
  logic [SW-1:0]    r_settle;
  logic             r_dut_x;
  logic             r_dut_y;
  logic             r_pass;
  logic [CNT_W-1:0] r_err;
  logic [3:0]       r_fail;
  logic             w_busy;
  logic             w_done;
  logic             w_mismatch;
  logic             w_last_vec;
  logic             w_last_pass;
  logic [1:0]       w_idx_inc;
  logic [CNT_W-1:0] w_err_nxt;

  // X/Z on the gate output is treated as a wrong answer in simulation
  assign w_mismatch  = (r_state == S_SAMPLE) && (dut_out !== r_tt[r_idx]);
  assign w_last_vec  = (r_idx == 2'd3);
  assign w_last_pass = (r_pass_cnt == LAST_PASS);
  assign w_idx_inc   = r_idx + 2'd1;
  assign w_err_nxt   = (w_mismatch && !(&r_err)) ? r_err + CNT_W'(1) : r_err;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = S_APPLY;
      end
      S_APPLY:  w_state_nxt = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
      S_SETTLE: if (r_settle == SW'(1)) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = (w_last_vec && w_last_pass) ? S_DONE : S_APPLY;
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // run datapath: table latch, vector/pass counters, gate drive, result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt       <= '0;
      r_idx      <= '0;
      r_pass_cnt <= '0;
      r_settle   <= '0;
      r_dut_x    <= 1'b0;
      r_dut_y    <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_fail     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tt       <= truth_table;
            r_err      <= '0;
            r_fail     <= '0;
            r_pass     <= 1'b0;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_dut_x    <= 1'b0;
            r_dut_y    <= 1'b0;
          end
        end
        S_APPLY:  r_settle <= SETTLE_LD;
        S_SETTLE: r_settle <= r_settle - SW'(1);
        S_SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_mismatch) r_fail[r_idx] <= 1'b1;
          // pass uses the post-sample count so it is valid in the same cycle as done
          if (w_last_vec && w_last_pass) begin
            r_pass <= (w_err_nxt == '0);
          end else begin
            // gate inputs only move here, i.e. on entry to APPLY
            r_idx   <= w_idx_inc;
            r_dut_x <= w_idx_inc[1];
            r_dut_y <= w_idx_inc[0];
            if (w_last_vec) r_pass_cnt <= r_pass_cnt + PW'(1);
          end
        end
        S_DONE: begin
          r_dut_x <= 1'b0;
          r_dut_y <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_CHAR_STUCK_DETECT_EN
  logic r_ref;
  logic r_same;
  logic r_stuck;
  logic w_same_now;
  logic w_tt_mixed;

  assign w_same_now = r_same && (dut_out === r_ref);
  assign w_tt_mixed = (r_tt != 4'b0000) && (r_tt != 4'b1111);

  // a pass whose four samples all agree while the table expects both values means the output is stuck
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref   <= 1'b0;
      r_same  <= 1'b0;
      r_stuck <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) r_stuck <= 1'b0;
    end else if (r_state == S_SAMPLE) begin
      if (r_idx == 2'd0) begin
        r_ref  <= dut_out;
        r_same <= 1'b1;
      end else begin
        r_same <= w_same_now;
        if (w_last_vec && w_same_now && w_tt_mixed) r_stuck <= 1'b1;
      end
    end
  end

  assign stuck = r_stuck;
`else
  assign stuck = 1'b0;
`endif

  assign busy      = w_busy;
  assign done      = w_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;
  assign dut_x     = r_dut_x;
  assign dut_y     = r_dut_y;

endmodule

// File: tb/tb_gate_char_sequencer.sv
// Bench for gate_char_sequencer: three parameterisations driven by a behavioural gate model,
// every cycle compared against a cycle-count based reference of the run schedule,
// plus literal end-of-run expectations for the directed cases.
module tb_gate_char_sequencer;

  localparam int SP  [3] = '{2, 0, 2};
  localparam int RP  [3] = '{1, 1, 3};
  localparam int CWP [3] = '{8, 8, 2};
`ifdef GATE_CHAR_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st    [3];
  logic [3:0] tt    [3];
  int         mode  [3];
  logic [3:0] gtab  [3];
  logic       dx    [3];
  logic       dy    [3];
  logic       dout  [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass_o[3];
  logic       stk   [3];
  logic [3:0] fv    [3];
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [7:0] errv  [3];

  int  n_chk  = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;

  // gate behaviour: 0 AND, 1 NAND, 2 tied 0, 3 AND with X on vector 1, 4 arbitrary table g
  function automatic logic gate_f(input int m, input logic [3:0] g, input int v);
    case (m)
      0:       return (v == 3);
      1:       return (v != 3);
      2:       return 1'b0;
      3:       return (v == 1) ? 1'bx : (v == 3);
      default: return g[v];
    endcase
  endfunction

  function automatic int run_len(input int i);
    return 4 * RP[i] * (SP[i] + 2);
  endfunction

  assign dout[0] = gate_f(mode[0], gtab[0], int'({dx[0], dy[0]}));
  assign dout[1] = gate_f(mode[1], gtab[1], int'({dx[1], dy[1]}));
  assign dout[2] = gate_f(mode[2], gtab[2], int'({dx[2], dy[2]}));
  assign errv[0] = err0;
  assign errv[1] = err1;
  assign errv[2] = {6'b0, err2};

  gate_char_sequencer #(.SETTLE_CYCLES(2), .REPEAT(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .truth_table(tt[0]), .dut_x(dx[0]), .dut_y(dy[0]),
    .dut_out(dout[0]), .busy(busy[0]), .done(done[0]), .pass(pass_o[0]), .err_count(err0),
    .fail_vec(fv[0]), .stuck(stk[0]));
  gate_char_sequencer #(.SETTLE_CYCLES(0), .REPEAT(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .truth_table(tt[1]), .dut_x(dx[1]), .dut_y(dy[1]),
    .dut_out(dout[1]), .busy(busy[1]), .done(done[1]), .pass(pass_o[1]), .err_count(err1),
    .fail_vec(fv[1]), .stuck(stk[1]));
  gate_char_sequencer #(.SETTLE_CYCLES(2), .REPEAT(3), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .truth_table(tt[2]), .dut_x(dx[2]), .dut_y(dy[2]),
    .dut_out(dout[2]), .busy(busy[2]), .done(done[2]), .pass(pass_o[2]), .err_count(err2),
    .fail_vec(fv[2]), .stuck(stk[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  bit         run  [3];
  int         k    [3];
  logic [3:0] mtt  [3];
  logic [3:0] mg   [3];
  int         mm   [3];
  int         h_err[3];
  logic [3:0] h_fail[3];
  bit         h_pass[3];
  bit         h_stk[3];

  // results after the first kk cycles of a run: every (S+2)-th cycle is a sample of vector (j/per)%4
  task automatic calc(input int i, input int kk, output int e, output logic [3:0] fl, output bit sk);
    int  per;
    int  emax;
    int  v;
    bit  same;
    bit  tt_ok;
    per   = SP[i] + 2;
    emax  = (1 << CWP[i]) - 1;
    e     = 0;
    fl    = 4'b0;
    sk    = 1'b0;
    same  = (gate_f(mm[i], mg[i], 0) === gate_f(mm[i], mg[i], 1)) &&
            (gate_f(mm[i], mg[i], 0) === gate_f(mm[i], mg[i], 2)) &&
            (gate_f(mm[i], mg[i], 0) === gate_f(mm[i], mg[i], 3));
    tt_ok = (mtt[i] != 4'b0000) && (mtt[i] != 4'b1111);
    for (int j = 0; j < kk; j++) begin
      if (j % per == per - 1) begin
        v = (j / per) % 4;
        if (gate_f(mm[i], mg[i], v) !== mtt[i][v]) begin
          if (e < emax) e++;
          fl[v] = 1'b1;
        end
        if (v == 3 && same && tt_ok && STUCK_EN) sk = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int         e;
      logic [3:0] f;
      bit         s;
      if (rst) begin
        run[i] = 1'b0; k[i] = 0;
        h_err[i] = 0; h_fail[i] = 4'b0; h_pass[i] = 1'b0; h_stk[i] = 1'b0;
      end else if (!run[i]) begin
        if (st[i]) begin
          run[i] = 1'b1; k[i] = 0;
          mtt[i] = tt[i]; mg[i] = gtab[i]; mm[i] = mode[i];
        end
      end else if (k[i] == run_len(i)) begin
        calc(i, run_len(i), e, f, s);
        h_err[i] = e; h_fail[i] = f; h_stk[i] = s; h_pass[i] = (e == 0);
        run[i] = 1'b0;
      end else begin
        k[i]++;
      end
    end
  end

  // per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          int         e;
          logic [3:0] f;
          bit         s;
          logic [17:0] ex;
          int         v;
          if (run[i]) begin
            calc(i, k[i], e, f, s);
            v  = (k[i] < run_len(i)) ? (k[i] / (SP[i] + 2)) % 4 : 3;
            ex = {1'b1, (k[i] == run_len(i)), v[1], v[0],
                  (k[i] == run_len(i)) && (e == 0), s, f, 8'(e)};
          end else begin
            ex = {1'b0, 1'b0, 1'b0, 1'b0, h_pass[i], h_stk[i], h_fail[i], 8'(h_err[i])};
          end
          chk($sformatf("cycle_inst%0d", i),
              32'({busy[i], done[i], dx[i], dy[i], pass_o[i], stk[i], fv[i], errv[i]}), 32'(ex));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // called at a negedge with instance i idle; returns at the done cycle with len = edges from accept
  task automatic run_one(input int i, input logic [3:0] t, input int m, input logic [3:0] g,
                         input bit noise, output int len);
    tt[i] = t; mode[i] = m; gtab[i] = g; st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    len = 0;
    while (done[i] !== 1'b1 && len < 400) begin
      @(negedge clk);
      len++;
      st[i] = noise && (len % 5 == 2);
    end
    st[i] = 1'b0;
    chk($sformatf("timeout_inst%0d", i), 32'(len >= 400), 32'd0);
  endtask

  initial begin
    int len;
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; tt[i] = 4'b0; mode[i] = 0; gtab[i] = 4'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_state", 32'({busy[0], done[0], dx[0], dy[0], pass_o[0], stk[0], fv[0], err0}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // correct AND cell
    run_one(0, 4'b1000, 0, 4'b0, 1'b0, len);
    chk("and_len", 32'(len), 32'd16);
    chk("and_result", 32'({pass_o[0], stk[0], fv[0], err0}), {18'd0, 1'b1, 1'b0, 4'h0, 8'd0});
    @(negedge clk);

    // NAND-style cell against AND table
    run_one(0, 4'b1000, 1, 4'b0, 1'b0, len);
    chk("nand_result", 32'({pass_o[0], stk[0], fv[0], err0}), {18'd0, 1'b0, 1'b0, 4'hF, 8'd4});
    @(negedge clk);

    // output tied low
    run_one(0, 4'b1000, 2, 4'b0, 1'b0, len);
    chk("tie0_result", 32'({pass_o[0], stk[0], fv[0], err0}), {18'd0, 1'b0, STUCK_EN, 4'h8, 8'd1});
    @(negedge clk);

    // three passes, table wrong only at {x,y}=10
    run_one(2, 4'b1100, 0, 4'b0, 1'b0, len);
    chk("rep3_len", 32'(len), 32'd48);
    chk("rep3_result", 32'({pass_o[2], fv[2], err2}), {25'd0, 1'b0, 4'b0100, 2'd3});
    @(negedge clk);

    // 12 mismatches into a 2-bit counter
    run_one(2, 4'b1000, 1, 4'b0, 1'b0, len);
    chk("sat_result", 32'({fv[2], err2}), {26'd0, 4'hF, 2'd3});
    @(negedge clk);

    // reset during SETTLE of vector 2 (cycle 9 after accept)
    tt[0] = 4'b1000; mode[0] = 1; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_vec", 32'({busy[0], dx[0], dy[0]}), 32'b110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst", 32'({busy[0], done[0], dx[0], dy[0], fv[0], err0}), 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);

    // start pulses while busy must not alter the run
    run_one(0, 4'b1000, 0, 4'b0, 1'b1, len);
    chk("busy_start_len", 32'(len), 32'd16);
    chk("busy_start_pass", 32'(pass_o[0]), 32'd1);
    @(negedge clk);

    // no settle, unknown output on vector 1
    run_one(1, 4'b1010, 3, 4'b0, 1'b0, len);
    chk("x_len", 32'(len), 32'd8);
    chk("x_result", 32'({pass_o[1], fv[1], err1}), {19'd0, 1'b0, 4'b0010, 8'd1});
    @(negedge clk);

    // randomized gates and tables across all three configurations
    for (int r = 0; r < 24; r++) begin
      int i;
      i = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_one(i, 4'($urandom), 4, 4'($urandom), 1'($urandom_range(0, 1)), len);
      chk($sformatf("rand_len_%0d", r), 32'(len), 32'(run_len(i)));
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
